// File: rtl/pixel_pkg.sv
// Shared types and raster helpers for the pixel stream transmitter.
package pixel_pkg;

  localparam int BEAT_COLOUR_W = 24;

  typedef struct packed {
    logic                     sop;
    logic                     eop;
    logic [BEAT_COLOUR_W-1:0] colour;
  } pixel_beat_t;

  typedef enum logic {SYNC, STREAM} state_t;

  // Raster starts at the top line (y = height-1) and ends at the right edge of line 0.
  function automatic int unsigned start_y(int unsigned height);
    return height - 1;
  endfunction

  function automatic int unsigned end_x(int unsigned width);
    return width - 1;
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Registered synchronous FIFO of pixel beats with full/empty flags.
module pixel_fifo
  import pixel_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        push,
  input  pixel_beat_t push_data,
  input  logic        pop,
  output pixel_beat_t pop_data,
  output logic        full,
  output logic        empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  pixel_beat_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the head is only observed while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/pixel_stream_tx.sv
// Checks incoming raster tuples against the expected position and frames
// accepted pixels into a valid/ready stream with SOP/EOP markers.
module pixel_stream_tx
  import pixel_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int RBG_SIZE      = BEAT_COLOUR_W,
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] xpixel_i,
  input  logic [DATA_WIDTH-1:0] ypixel_i,
  input  logic [RBG_SIZE-1:0]   colour_i,
  output logic                  ready_o,
  output logic [RBG_SIZE-1:0]   out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic                  frame_err,
  output logic [15:0]           frame_count
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] x;
    logic [DATA_WIDTH-1:0] y;
  } pos_t;

  localparam logic [DATA_WIDTH-1:0] ONE     = DATA_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] START_X = '0;
  localparam logic [DATA_WIDTH-1:0] START_Y = DATA_WIDTH'(start_y(SCREEN_HEIGHT));
  localparam logic [DATA_WIDTH-1:0] END_X   = DATA_WIDTH'(end_x(SCREEN_WIDTH));
  localparam logic [DATA_WIDTH-1:0] END_Y   = '0;
  localparam pos_t START_POS = '{x: START_X, y: START_Y};

  function automatic pos_t advance(pos_t p);
    pos_t n;
    if (p.x == END_X) begin
      n.x = START_X;
      n.y = (p.y == END_Y) ? START_Y : p.y - ONE;
    end else begin
      n.x = p.x + ONE;
      n.y = p.y;
    end
    return n;
  endfunction

  state_t      state_q, state_d;
  pos_t        exp_q, exp_d;
  pos_t        in_pos;
  logic        accept;
  logic        is_start, is_end, is_exp;
  logic        push;
  logic        err_d;
  pixel_beat_t push_beat;
  pixel_beat_t head;
  logic        fifo_full, fifo_empty;
  logic        pop;

  assign in_pos   = '{x: xpixel_i, y: ypixel_i};
  assign ready_o  = ~fifo_full;
  assign accept   = en & ready_o;
  assign is_start = (in_pos == START_POS);
  assign is_end   = (xpixel_i == END_X) && (ypixel_i == END_Y);
  assign is_exp   = (in_pos == exp_q);

  always_comb begin
    state_d          = state_q;
    exp_d            = exp_q;
    push             = 1'b0;
    err_d            = 1'b0;
    push_beat.sop    = is_start;
    push_beat.eop    = is_end;
    push_beat.colour = colour_i;
    if (accept) begin
      case (state_q)
        SYNC: begin
          if (is_start) begin
            push    = 1'b1;
            state_d = STREAM;
            exp_d   = advance(START_POS);
          end
        end
        STREAM: begin
          if (is_exp) begin
            push  = 1'b1;
            exp_d = advance(exp_q);
          end else begin
            // A stray start pixel restarts the frame instead of forcing a resync.
            err_d = 1'b1;
            if (is_start) begin
              push  = 1'b1;
              exp_d = advance(START_POS);
            end else begin
              state_d = SYNC;
              exp_d   = START_POS;
            end
          end
        end
        default: state_d = SYNC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= SYNC;
      exp_q     <= START_POS;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      exp_q     <= exp_d;
      frame_err <= err_d;
    end
  end

  pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_beat),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;
  assign out_data  = out_valid ? head.colour : '0;
  assign out_sop   = out_valid & head.sop;
  assign out_eop   = out_valid & head.eop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_count <= '0;
    end else if (pop && head.eop) begin
      frame_count <= frame_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_pixel_stream_tx.sv
// Self-checking bench for pixel_stream_tx on a 4x3 screen with a 4-entry FIFO.
module tb_pixel_stream_tx;

  localparam int W = 4;
  localparam int H = 3;
  localparam int D = 4;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        en = 1'b0;
  logic [31:0] xpixel_i = '0;
  logic [31:0] ypixel_i = '0;
  logic [23:0] colour_i = '0;
  logic        out_ready = 1'b0;
  logic        ready_o;
  logic [23:0] out_data;
  logic        out_valid;
  logic        out_sop;
  logic        out_eop;
  logic        frame_err;
  logic [15:0] frame_count;

  always #5 clk = ~clk;

  pixel_stream_tx #(
    .DATA_WIDTH(32), .RBG_SIZE(24), .SCREEN_WIDTH(W),
    .SCREEN_HEIGHT(H), .FIFO_DEPTH(D)
  ) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .xpixel_i(xpixel_i),
    .ypixel_i(ypixel_i), .colour_i(colour_i), .ready_o(ready_o),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sop(out_sop), .out_eop(out_eop), .frame_err(frame_err),
    .frame_count(frame_count)
  );

  typedef struct {
    logic [23:0] colour;
    bit          sop;
    bit          eop;
  } beat_t;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    bit          ev;
    bit          esop;
    bit          eeop;
    bit          eerr;
  } vec_t;

  beat_t mq[$];
  vec_t  tbl[$];
  int    total = 0;
  int    bad = 0;
  bit    synced;
  int    exp_idx;
  bit    err_pending;
  int    fc;
  int    beats_seen, sop_seen, eop_seen;
  bit    last_acc;

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [31:0] px(int idx);
    return 32'(idx % W);
  endfunction

  function automatic logic [31:0] py(int idx);
    return 32'(H - 1 - idx / W);
  endfunction

  // Linear raster index of a tuple, or -1 if it lies off-screen.
  function automatic int pos_index(logic [31:0] x, logic [31:0] y);
    if (x < W && y < H) return (H - 1 - int'(y)) * W + int'(x);
    return -1;
  endfunction

  task automatic model_reset();
    mq.delete();
    synced = 0;
    exp_idx = 0;
    err_pending = 0;
    fc = 0;
  endtask

  task automatic clear_tally();
    beats_seen = 0;
    sop_seen = 0;
    eop_seen = 0;
  endtask

  // One clock: drive at the falling edge, check, update the model, advance.
  task automatic applyStimulus(bit e, logic [31:0] x, logic [31:0] y, logic [23:0] c, bit rdy);
    int    idx;
    beat_t b;
    en = e; xpixel_i = x; ypixel_i = y; colour_i = c; out_ready = rdy;
    #1;
    checkOutput("ready_o", 32'(ready_o), 32'(mq.size() < D));
    checkOutput("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      checkOutput("out_data", 32'(out_data), 32'(mq[0].colour));
      checkOutput("out_sop", 32'(out_sop), 32'(mq[0].sop));
      checkOutput("out_eop", 32'(out_eop), 32'(mq[0].eop));
    end
    checkOutput("frame_err", 32'(frame_err), 32'(err_pending));
    checkOutput("frame_count", 32'(frame_count), 32'(fc));
    last_acc = e && (mq.size() < D);
    if (mq.size() > 0 && rdy) begin
      b = mq.pop_front();
      beats_seen++;
      sop_seen += int'(b.sop);
      eop_seen += int'(b.eop);
      if (b.eop) fc = (fc + 1) % 65536;
    end
    err_pending = 0;
    if (last_acc) begin
      idx = pos_index(x, y);
      if (!synced) begin
        if (idx == 0) begin
          mq.push_back('{c, 1'b1, N == 1});
          synced = 1;
          exp_idx = 1 % N;
        end
      end else if (idx == exp_idx) begin
        mq.push_back('{c, idx == 0, idx == N - 1});
        exp_idx = (idx + 1) % N;
      end else begin
        err_pending = 1;
        if (idx == 0) begin
          mq.push_back('{c, 1'b1, N == 1});
          exp_idx = 1 % N;
        end else begin
          synced = 0;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_pixel(int idx, bit rdy);
    for (int t = 0; t < 50; t++) begin
      applyStimulus(1'b1, px(idx), py(idx), 24'($urandom), rdy);
      if (last_acc) return;
    end
    checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, '0, 1'b1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    en = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'd0);
    checkOutput("rst_out_sop", 32'(out_sop), 32'd0);
    checkOutput("rst_out_eop", 32'(out_eop), 32'd0);
    checkOutput("rst_frame_err", 32'(frame_err), 32'd0);
    checkOutput("rst_frame_count", 32'(frame_count), 32'd0);
    checkOutput("rst_ready_o", 32'(ready_o), 32'd1);
    reset_n = 1'b1;
  endtask

  initial begin
    int gen_idx;
    int r;
    int sent_idx;
    logic [31:0] gx, gy;

    // Mismatch / resync / restart walk: each row's effect is visible one cycle later.
    tbl.push_back('{32'd0, 32'd2, 1, 1, 0, 0});
    tbl.push_back('{32'd1, 32'd2, 1, 0, 0, 0});
    tbl.push_back('{32'd3, 32'd2, 0, 0, 0, 1});
    tbl.push_back('{32'd2, 32'd2, 0, 0, 0, 0});
    tbl.push_back('{32'd0, 32'd2, 1, 1, 0, 0});
    tbl.push_back('{32'd1, 32'd2, 1, 0, 0, 0});
    tbl.push_back('{32'd2, 32'd2, 1, 0, 0, 0});
    tbl.push_back('{32'd3, 32'd2, 1, 0, 0, 0});
    tbl.push_back('{32'd0, 32'd1, 1, 0, 0, 0});
    tbl.push_back('{32'd0, 32'd2, 1, 1, 0, 1});
    for (int i = 1; i < N; i++)
      tbl.push_back('{px(i), py(i), 1, 0, i == N - 1, 0});

    @(negedge clk);
    do_reset();

    clear_tally();
    for (int i = 0; i < N; i++) send_pixel(i, 1'b1);
    idle(2);
    checkOutput("full_beats", 32'(beats_seen), 32'd12);
    checkOutput("full_sop", 32'(sop_seen), 32'd1);
    checkOutput("full_eop", 32'(eop_seen), 32'd1);
    checkOutput("full_frame_count", 32'(frame_count), 32'd1);

    do_reset();
    clear_tally();
    for (int i = 0; i < D; i++) send_pixel(i, 1'b0);
    checkOutput("bp_ready_low", 32'(ready_o), 32'd0);
    applyStimulus(1'b1, px(D), py(D), 24'h123456, 1'b0);
    checkOutput("bp_held_not_accepted", 32'(last_acc), 32'd0);
    for (int i = D; i < 6; i++) send_pixel(i, 1'b1);
    idle(8);
    checkOutput("bp_delivered", 32'(beats_seen), 32'd6);

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(1'b1, tbl[i].x, tbl[i].y, 24'($urandom), 1'b1);
      checkOutput($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
      checkOutput($sformatf("tbl%0d_sop", i), 32'(out_sop), 32'(tbl[i].esop));
      checkOutput($sformatf("tbl%0d_eop", i), 32'(out_eop), 32'(tbl[i].eeop));
      checkOutput($sformatf("tbl%0d_err", i), 32'(frame_err), 32'(tbl[i].eerr));
      if (i == 9) checkOutput("restart_frame_count", 32'(frame_count), 32'd0);
    end
    idle(2);
    checkOutput("tbl_frame_count", 32'(frame_count), 32'd1);

    do_reset();
    clear_tally();
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < N; i++) send_pixel(i, 1'b1);
    idle(3);
    checkOutput("b2b_beats", 32'(beats_seen), 32'd24);
    checkOutput("b2b_sop", 32'(sop_seen), 32'd2);
    checkOutput("b2b_eop", 32'(eop_seen), 32'd2);
    checkOutput("b2b_frame_count", 32'(frame_count), 32'd2);

    // Asynchronous reset between clock edges with data pending.
    for (int i = 0; i < 3; i++) send_pixel(i, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_out_valid", 32'(out_valid), 32'd0);
    checkOutput("async_frame_count", 32'(frame_count), 32'd0);
    checkOutput("async_ready_o", 32'(ready_o), 32'd1);
    model_reset();
    en = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(1'b1, px(1), py(1), 24'hABCDEF, 1'b1);
    applyStimulus(1'b0, '0, '0, '0, 1'b1);
    checkOutput("post_reset_needs_start", 32'(out_valid), 32'd0);

    // Randomised traffic against the reference model.
    gen_idx = 0;
    for (int c = 0; c < 800; c++) begin
      r = $urandom_range(0, 9);
      sent_idx = -2;
      if (r < 8) begin
        gx = px(gen_idx); gy = py(gen_idx); sent_idx = gen_idx;
      end else if (r == 8) begin
        gx = 32'($urandom_range(0, W)); gy = 32'($urandom_range(0, H));
      end else begin
        gx = px(0); gy = py(0); sent_idx = 0;
      end
      applyStimulus($urandom_range(0, 4) != 0, gx, gy, 24'($urandom),
                    $urandom_range(0, 3) != 0);
      if (last_acc && sent_idx >= 0) gen_idx = (sent_idx + 1) % N;
    end
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
